// File: rtl/gem_pkg.sv
// Shared definitions for the GEM cluster front end: cluster field layout
// and the VFAT-to-FEB mapping used by the decoder.
package gem_pkg;

    localparam int ADR_LSB = 0;
    localparam int ADR_MSB = 10;
    localparam int CNT_LSB = 11;
    localparam int CNT_MSB = 13;
    localparam int VFAT_LSB = ADR_LSB + 6;

    localparam logic [4:0] FEB_INVALID = 5'd24;

    // VFATs 0,1,2 sit on FEBs 0,8,16; every third VFAT advances the FEB by one.
    function automatic logic [4:0] vfat_to_feb(input logic [4:0] vfat);
        logic [4:0] feb;
        if (vfat < 5'd24) begin
            feb = ((vfat % 5'd3) * 5'd8) + (vfat / 5'd3);
        end else begin
            feb = FEB_INVALID;
        end
        return feb;
    endfunction

endpackage

// File: rtl/gem_feb_stretch.sv
// Per-FEB activity stretcher: holds the active bit for 1+stretch_bx bx
// after the most recent hit, retriggering on every new hit.
module gem_feb_stretch #(
    parameter int STRW = 4
) (
    input  logic            clock,
    input  logic            global_reset,
    input  logic            hit,
    input  logic [STRW-1:0] stretch_bx,
    output logic            active
);

    localparam logic [STRW-1:0] TIMER_ONE = {{(STRW-1){1'b0}}, 1'b1};

    logic [STRW-1:0] timer_r;
    logic            active_r;

    // Load on hit, otherwise count a running timer down to zero.
    always_ff @(posedge clock) begin
        if (global_reset) begin
            timer_r  <= '0;
            active_r <= 1'b0;
        end else begin
            active_r <= hit | (timer_r != '0);
            if (hit) begin
                timer_r <= stretch_bx;
            end else if (timer_r != '0) begin
                timer_r <= timer_r - TIMER_ONE;
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    assign active = active_r;

endmodule

// File: rtl/gem_cluster_decoder.sv
// GEM cluster front end: registers incoming clusters with valid flags,
// builds the stretched active-FEB list and keeps per-FEB hit counters.
module gem_cluster_decoder
    import gem_pkg::*;
#(
    parameter int MXCLST   = 8,
    parameter int CLSTBITS = 14,
    parameter int MXFEB    = 24,
    parameter int STRW     = 4,
    parameter int HCW      = 16
) (
    input  logic                         clock,
    input  logic                         global_reset,
    input  logic [MXCLST*CLSTBITS-1:0]   gemdata,
    input  logic [STRW-1:0]              stretch_bx,
    input  logic                         cnt_clear,
    input  logic [4:0]                   cnt_sel,
    output logic [MXCLST*CLSTBITS-1:0]   cluster_q,
    output logic [MXCLST-1:0]            vpf_q,
    output logic [3:0]                   ncluster,
    output logic                         overflow,
    output logic [MXFEB-1:0]             active_feb_list,
    output logic [HCW-1:0]               hit_cnt
);

    localparam int NCW = 4;
    localparam logic [NCW-1:0] NCL_ONE = {{(NCW-1){1'b0}}, 1'b1};
    localparam logic [4:0]     FEB_NUM = 5'(MXFEB);

    logic [MXCLST-1:0]          vpf_s;
    logic [NCW-1:0]             ncl_s;
    logic [MXCLST*CLSTBITS-1:0] cluster_r;
    logic [MXCLST-1:0]          vpf_r;
    logic [NCW-1:0]             ncl_r;
    logic                       ovf_r;
    logic [4:0]                 feb_s   [MXCLST];
    logic [MXFEB-1:0]           hit_s;
    logic [NCW-1:0]             add_s   [MXFEB];
    logic [HCW:0]               sum_s   [MXFEB];
    logic [HCW-1:0]             cnt_nxt_s [MXFEB];
    logic [HCW-1:0]             cnt_r   [MXFEB];
    logic [HCW-1:0]             hit_cnt_r;
    logic [MXFEB-1:0]           afl_s;

    // Valid flag and popcount of the incoming bx (adr[10:9]==2'b11 marks an empty slot).
    always_comb begin
        ncl_s = '0;
        for (int i = 0; i < MXCLST; i++) begin
            vpf_s[i] = ~(gemdata[i*CLSTBITS+ADR_LSB+9 +: 2] == 2'b11);
            ncl_s    = ncl_s + (vpf_s[i] ? NCL_ONE : '0);
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clock) begin
        if (global_reset) begin
            cluster_r <= '0;
            vpf_r     <= '0;
            ncl_r     <= '0;
            ovf_r     <= 1'b0;
        end else begin
            cluster_r <= gemdata;
            vpf_r     <= vpf_s;
            ncl_r     <= ncl_s;
            ovf_r     <= &vpf_s;
        end
    end

    // FEB id of each registered cluster.
    always_comb begin
        for (int i = 0; i < MXCLST; i++) begin
            feb_s[i] = vfat_to_feb(cluster_r[i*CLSTBITS+VFAT_LSB +: 5]);
        end
    end

    // Per-FEB hit flag and number of valid clusters; invalid FEB ids match nothing.
    always_comb begin
        for (int f = 0; f < MXFEB; f++) begin
            hit_s[f] = 1'b0;
            add_s[f] = '0;
            for (int i = 0; i < MXCLST; i++) begin
                if (vpf_r[i] && (feb_s[i] == 5'(f))) begin
                    hit_s[f] = 1'b1;
                    add_s[f] = add_s[f] + NCL_ONE;
                end else begin
                    hit_s[f] = hit_s[f];
                    add_s[f] = add_s[f];
                end
            end
        end
    end

    // Saturating next value for every hit counter.
    always_comb begin
        for (int f = 0; f < MXFEB; f++) begin
            sum_s[f] = {1'b0, cnt_r[f]} + {{(HCW+1-NCW){1'b0}}, add_s[f]};
            if (sum_s[f][HCW]) begin
                cnt_nxt_s[f] = '1;
            end else begin
                cnt_nxt_s[f] = sum_s[f][HCW-1:0];
            end
        end
    end

    // Hit counters; clear wins over the increment of the same bx.
    always_ff @(posedge clock) begin
        if (global_reset || cnt_clear) begin
            for (int f = 0; f < MXFEB; f++) begin
                cnt_r[f] <= '0;
            end
        end else begin
            for (int f = 0; f < MXFEB; f++) begin
                cnt_r[f] <= cnt_nxt_s[f];
            end
        end
    end

    // Registered counter readback; out-of-range selects read zero.
    always_ff @(posedge clock) begin
        if (global_reset) begin
            hit_cnt_r <= '0;
        end else if (cnt_sel < FEB_NUM) begin
            hit_cnt_r <= cnt_r[cnt_sel];
        end else begin
            hit_cnt_r <= '0;
        end
    end

    for (genvar f = 0; f < MXFEB; f++) begin : g_feb
        gem_feb_stretch #(
            .STRW(STRW)
        ) u_stretch (
            .clock       (clock),
            .global_reset(global_reset),
            .hit         (hit_s[f]),
            .stretch_bx  (stretch_bx),
            .active      (afl_s[f])
        );
    end

    assign cluster_q       = cluster_r;
    assign vpf_q           = vpf_r;
    assign ncluster        = ncl_r;
    assign overflow        = ovf_r;
    assign active_feb_list = afl_s;
    assign hit_cnt         = hit_cnt_r;

endmodule

// File: tb/tb_gem_cluster_decoder.sv
// Directed bench: the driver queues hand-computed expectations, a monitor
// pops and compares them when each output becomes due.
module tb_gem_cluster_decoder;

    logic         clock;
    logic         global_reset;
    logic [111:0] gemdata;
    logic [3:0]   stretch_bx;
    logic         cnt_clear;
    logic [4:0]   cnt_sel;
    logic [111:0] cluster_q;
    logic [7:0]   vpf_q;
    logic [3:0]   ncluster;
    logic         overflow;
    logic [23:0]  active_feb_list;
    logic [15:0]  hit_cnt;

    gem_cluster_decoder dut (
        .clock          (clock),
        .global_reset   (global_reset),
        .gemdata        (gemdata),
        .stretch_bx     (stretch_bx),
        .cnt_clear      (cnt_clear),
        .cnt_sel        (cnt_sel),
        .cluster_q      (cluster_q),
        .vpf_q          (vpf_q),
        .ncluster       (ncluster),
        .overflow       (overflow),
        .active_feb_list(active_feb_list),
        .hit_cnt        (hit_cnt)
    );

    typedef struct {
        int           due;
        logic [111:0] cl;
        logic [7:0]   vpf;
        bit           chkc;
        logic [15:0]  cnt;
    } s1_t;

    typedef struct {
        int          due;
        logic [23:0] afl;
    } s2_t;

    s1_t q1[$];
    s2_t q2[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [111:0] rep(input logic [10:0] a, input logic [7:0] m);
        logic [111:0] g;
        for (int i = 0; i < 8; i++) begin
            g[i*14 +: 14] = m[i] ? {3'd5, a} : {3'd2, 11'h600};
        end
        return g;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // c1: check stage-1 outputs, ev: expected vpf, cc/ec: hit_cnt check, c2/ea: active list check
    task automatic step(input logic [111:0] gd, input logic [3:0] sb, input logic clr,
                        input logic [4:0] sel, input logic rst,
                        input bit c1, input logic [7:0] ev,
                        input bit cc, input logic [15:0] ec,
                        input bit c2, input logic [23:0] ea);
        s1_t a;
        s2_t b;
        @(negedge clock);
        gemdata      = gd;
        stretch_bx   = sb;
        cnt_clear    = clr;
        cnt_sel      = sel;
        global_reset = rst;
        if (c1 || cc) begin
            a.due  = cyc + 1;
            a.cl   = rst ? 112'd0 : gd;
            a.vpf  = rst ? 8'd0 : ev;
            a.chkc = cc;
            a.cnt  = ec;
            q1.push_back(a);
        end
        if (c2) begin
            b.due = cyc + 2;
            b.afl = ea;
            q2.push_back(b);
        end
    endtask

    // Monitor: compare every queued expectation on the cycle it falls due.
    always @(negedge clock) begin
        s1_t a;
        s2_t b;
        if (q1.size() > 0 && q1[0].due <= cyc) begin
            a = q1.pop_front();
            if (a.due != cyc) chk("s1_late", 128'(cyc), 128'(a.due));
            chk("cluster_q", 128'(cluster_q), 128'(a.cl));
            chk("vpf_q", 128'(vpf_q), 128'(a.vpf));
            chk("ncluster", 128'(ncluster), 128'($countones(a.vpf)));
            chk("overflow", 128'(overflow), 128'(&a.vpf));
            if (a.chkc) chk("hit_cnt", 128'(hit_cnt), 128'(a.cnt));
        end
        if (q2.size() > 0 && q2[0].due <= cyc) begin
            b = q2.pop_front();
            if (b.due != cyc) chk("s2_late", 128'(cyc), 128'(b.due));
            chk("active_feb_list", 128'(active_feb_list), 128'(b.afl));
        end
    end

    initial begin
        logic [111:0] idle, h8, all23, gd5;
        global_reset = 1'b1;
        gemdata      = 112'd0;
        stretch_bx   = 4'd0;
        cnt_clear    = 1'b0;
        cnt_sel      = 5'd0;
        idle  = rep(11'h600, 8'h00);
        h8    = rep(11'h040, 8'h01);
        all23 = rep(11'h5C0, 8'hFF);
        gd5   = idle;
        gd5[13:0]  = {3'd1, 11'h5FF};
        gd5[27:14] = {3'd0, 11'h600};
        gd5[41:28] = {3'd7, 11'h7FF};

        // reset with live traffic on the input
        repeat (2) step(rep(11'h040, 8'hFF), 4'd0, 1'b0, 5'd0, 1'b1, 1, 8'h00, 1, 16'd0, 1, 24'h0);
        // empty clusters
        repeat (3) step(idle, 4'd0, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd0, 1, 24'h0);
        // single hit on vfat1 -> feb8, no stretch
        step(h8,   4'd0, 1'b0, 5'd8, 1'b0, 1, 8'h01, 1, 16'd0, 1, 24'h000100);
        step(idle, 4'd0, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd0, 1, 24'h0);
        step(idle, 4'd0, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd1, 1, 24'h0);
        // stretch 3 with a retrigger two bx later
        step(idle, 4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd1, 1, 24'h0);
        step(h8,   4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h01, 1, 16'd1, 1, 24'h000100);
        step(idle, 4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd1, 1, 24'h000100);
        step(h8,   4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h01, 1, 16'd2, 1, 24'h000100);
        step(idle, 4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd2, 1, 24'h000100);
        step(idle, 4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd3, 1, 24'h000100);
        step(idle, 4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd3, 1, 24'h000100);
        step(idle, 4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd3, 1, 24'h0);
        step(idle, 4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd3, 1, 24'h0);
        // all eight clusters on vfat23 -> feb23, overflow
        step(all23, 4'd0, 1'b0, 5'd23, 1'b0, 1, 8'hFF, 1, 16'd0, 1, 24'h800000);
        step(all23, 4'd0, 1'b0, 5'd23, 1'b0, 1, 8'hFF, 1, 16'd0, 1, 24'h800000);
        step(idle,  4'd0, 1'b0, 5'd23, 1'b0, 1, 8'h00, 1, 16'd8, 1, 24'h0);
        step(idle,  4'd0, 1'b0, 5'd23, 1'b0, 1, 8'h00, 1, 16'd16, 1, 24'h0);
        // 5FF is the top valid address (feb23); 600 and 7FF are empty slots
        step(gd5,  4'd0, 1'b0, 5'd23, 1'b0, 1, 8'h01, 1, 16'd16, 1, 24'h800000);
        step(idle, 4'd0, 1'b0, 5'd23, 1'b0, 1, 8'h00, 1, 16'd16, 1, 24'h0);
        step(idle, 4'd0, 1'b0, 5'd23, 1'b0, 1, 8'h00, 1, 16'd17, 1, 24'h0);
        step(idle, 4'd0, 1'b0, 5'd24, 1'b0, 1, 8'h00, 1, 16'd0, 1, 24'h0);
        step(idle, 4'd0, 1'b0, 5'd31, 1'b0, 1, 8'h00, 1, 16'd0, 1, 24'h0);
        // pump feb0 to 65528, then 4 hits/bx into saturation
        repeat (8191) step(rep(11'h000, 8'hFF), 4'd0, 1'b0, 5'd0, 1'b0, 0, 8'h00, 0, 16'd0, 0, 24'h0);
        step(rep(11'h000, 8'h0F), 4'd0, 1'b0, 5'd0, 1'b0, 1, 8'h0F, 1, 16'hFFF0, 1, 24'h000001);
        step(rep(11'h000, 8'h0F), 4'd0, 1'b0, 5'd0, 1'b0, 1, 8'h0F, 1, 16'hFFF8, 1, 24'h000001);
        step(rep(11'h000, 8'h0F), 4'd0, 1'b0, 5'd0, 1'b0, 1, 8'h0F, 1, 16'hFFFC, 1, 24'h000001);
        step(idle, 4'd0, 1'b0, 5'd0, 1'b0, 1, 8'h00, 1, 16'hFFFF, 1, 24'h0);
        step(idle, 4'd0, 1'b0, 5'd0, 1'b0, 1, 8'h00, 1, 16'hFFFF, 1, 24'h0);
        // clear in the bx where a 4-hit cluster set reaches the counters
        step(rep(11'h000, 8'h0F), 4'd0, 1'b0, 5'd0, 1'b0, 1, 8'h0F, 1, 16'hFFFF, 1, 24'h000001);
        step(idle, 4'd0, 1'b1, 5'd0,  1'b0, 1, 8'h00, 1, 16'hFFFF, 1, 24'h0);
        step(idle, 4'd0, 1'b0, 5'd0,  1'b0, 1, 8'h00, 1, 16'd0, 1, 24'h0);
        step(idle, 4'd0, 1'b0, 5'd23, 1'b0, 1, 8'h00, 1, 16'd0, 1, 24'h0);
        step(idle, 4'd0, 1'b0, 5'd8,  1'b0, 1, 8'h00, 1, 16'd0, 1, 24'h0);
        // reset in the middle of a stretch, then refill
        step(h8,   4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h01, 1, 16'd0, 1, 24'h000100);
        step(idle, 4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd0, 1, 24'h0);
        step(idle, 4'd3, 1'b0, 5'd8, 1'b1, 1, 8'h00, 1, 16'd0, 1, 24'h0);
        step(h8,   4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h01, 1, 16'd0, 1, 24'h000100);
        step(idle, 4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd0, 1, 24'h000100);
        step(idle, 4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd1, 1, 24'h000100);
        step(idle, 4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd1, 1, 24'h000100);
        step(idle, 4'd3, 1'b0, 5'd8, 1'b0, 1, 8'h00, 1, 16'd1, 1, 24'h0);

        for (int i = 0; i < 20 && (q1.size() > 0 || q2.size() > 0); i++) @(negedge clock);
        #1;
        if (q1.size() > 0 || q2.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations still pending, required 0", q1.size() + q2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
